// File: rtl/pedestrian_request_ctrl.sv
// Pedestrian push-button front end: synchroniser, debouncer and a single-request
// holder that waits for pietoni_verde, then enforces a cooldown before re-arming.
module pedestrian_request_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       buton_raw,
  input  logic       pietoni_verde,
  output logic       buton_pietoni,
  output logic       req_pending,
  output logic       req_served,
  output logic       cooldown,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {IDLE, PENDING, SERVING, COOLDOWN} state_t;

  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   deb_q, deb_d;
  logic                   deb_prev_q, deb_prev_d;
  logic [CNT_W-1:0]       dcnt_q, dcnt_d;
  logic [CNT_W-1:0]       ccnt_q, ccnt_d;
  state_t                 state_q, state_d;
  logic                   buton_q, buton_d;
  logic                   pend_q, pend_d;
  logic                   served_q, served_d;
  logic                   cool_q, cool_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   sync_out;
  logic                   press;
  logic [CNT_W-1:0]       dcnt_inc;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Debounce: deb follows sync_out only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], buton_raw};
    dcnt_inc   = dcnt_q + CNT_W'(1);
    deb_d      = deb_q;
    dcnt_d     = '0;
    deb_prev_d = deb_q;
    if (sync_out != deb_q) begin
      if (dcnt_inc == DEB_MAX) begin
        deb_d = sync_out;
      end else begin
        dcnt_d = dcnt_inc;
      end
    end
    press = deb_q & ~deb_prev_q;
  end

  // Request FSM; decisions always use the current state, so a press on the
  // COOLDOWN->IDLE edge or alongside the ack in PENDING is dropped.
  always_comb begin
    state_d  = state_q;
    ccnt_d   = ccnt_q;
    cnt_d    = cnt_q;
    served_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press && !pietoni_verde) begin
          state_d = PENDING;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end
      PENDING: begin
        if (pietoni_verde) state_d = SERVING;
      end
      SERVING: begin
        if (!pietoni_verde) begin
          state_d  = COOLDOWN;
          served_d = 1'b1;
          ccnt_d   = COOL_LOAD;
        end
      end
      COOLDOWN: begin
        if (ccnt_q == '0) begin
          state_d = IDLE;
        end else begin
          ccnt_d = ccnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    buton_d = (state_d == PENDING);
    pend_d  = (state_d == PENDING) || (state_d == SERVING);
    cool_d  = (state_d == COOLDOWN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      dcnt_q     <= '0;
      ccnt_q     <= '0;
      state_q    <= IDLE;
      buton_q    <= 1'b0;
      pend_q     <= 1'b0;
      served_q   <= 1'b0;
      cool_q     <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      sync_q     <= sync_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      dcnt_q     <= dcnt_d;
      ccnt_q     <= ccnt_d;
      state_q    <= state_d;
      buton_q    <= buton_d;
      pend_q     <= pend_d;
      served_q   <= served_d;
      cool_q     <= cool_d;
      cnt_q      <= cnt_d;
    end
  end

  assign buton_pietoni = buton_q;
  assign req_pending   = pend_q;
  assign req_served    = served_q;
  assign cooldown      = cool_q;
  assign press_cnt     = cnt_q;

endmodule

// File: tb/tb_pedestrian_request_ctrl.sv
// Bench for pedestrian_request_ctrl: directed scenarios plus random traffic,
// all compared cycle by cycle against a phase/queue based reference model.
module tb_pedestrian_request_ctrl;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int COOL = 16;
  localparam int LAT  = SYNC + DEB + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       buton_raw;
  logic       pietoni_verde;
  logic       buton_pietoni;
  logic       req_pending;
  logic       req_served;
  logic       cooldown;
  logic [7:0] press_cnt;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  // Reference model state: raw sample history, recent synchronised samples,
  // and the request phase as flags plus remaining cooldown cycles.
  bit m_hist[SYNC];
  bit m_log[$];
  bit m_deb, m_deb_prev, m_pend, m_serv, m_served;
  int m_cool_left, m_cnt;

  logic [11:0] dut_vec, exp_vec;

  pedestrian_request_ctrl #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .COOLDOWN_CYCLES(COOL), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .buton_raw(buton_raw), .pietoni_verde(pietoni_verde),
    .buton_pietoni(buton_pietoni), .req_pending(req_pending), .req_served(req_served),
    .cooldown(cooldown), .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  assign dut_vec = {buton_pietoni, req_pending, req_served, cooldown, press_cnt};
  assign exp_vec = {m_pend, m_pend | m_serv, m_served, m_cool_left > 0, m_cnt[7:0]};

  task automatic model_edge();
    bit sync_out, press, flip;
    if (!rst_n) begin
      foreach (m_hist[i]) m_hist[i] = 1'b0;
      m_log.delete();
      m_deb = 0; m_deb_prev = 0; m_pend = 0; m_serv = 0; m_served = 0;
      m_cool_left = 0; m_cnt = 0;
      return;
    end
    sync_out = m_hist[SYNC-1];
    press = m_deb && !m_deb_prev;
    m_deb_prev = m_deb;
    m_log.push_back(sync_out);
    if (m_log.size() > DEB) void'(m_log.pop_front());
    flip = (m_log.size() == DEB);
    foreach (m_log[i]) if (m_log[i] == m_deb) flip = 1'b0;
    if (flip) m_deb = sync_out;
    for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = buton_raw;
    m_served = 1'b0;
    if (m_cool_left > 0) begin
      m_cool_left--;
    end else if (m_serv) begin
      if (!pietoni_verde) begin m_serv = 0; m_served = 1; m_cool_left = COOL; end
    end else if (m_pend) begin
      if (pietoni_verde) begin m_pend = 0; m_serv = 1; end
    end else if (press && !pietoni_verde) begin
      m_pend = 1;
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    int edges;
    rst_n = 1'b0; buton_raw = 1'b1; pietoni_verde = 1'b0;
    repeat (3) tick();
    n_chk++; if (dut_vec !== 12'h000) begin n_err++; $display("FAIL reset_outputs got=%h want=000", dut_vec); end
    rst_n = 1'b1;
    edges = 0;
    while (buton_pietoni !== 1'b1 && edges < 40) begin
      tick(); edges++;
      n_chk++; if (dut_vec !== exp_vec) begin n_err++; $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
    end
    n_chk++; if (edges != LAT) begin n_err++; $display("FAIL reset_first_press got=%0d edges want=%0d", edges, LAT); end
  endtask

  task automatic test_serve();
    int served_cnt = 0, cool_cnt = 0;
    buton_raw = 1'b0; pietoni_verde = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_chk++; if (dut_vec !== exp_vec) begin n_err++; $display("FAIL serve_green cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
      if (i == 0) begin
        n_chk++; if (buton_pietoni !== 1'b0 || req_pending !== 1'b1) begin n_err++; $display("FAIL serve_ack got=%b%b want=01", buton_pietoni, req_pending); end
      end
    end
    pietoni_verde = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      n_chk++; if (dut_vec !== exp_vec) begin n_err++; $display("FAIL serve_cool cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
      if (req_served === 1'b1) served_cnt++;
      if (cooldown === 1'b1) cool_cnt++;
    end
    n_chk++; if (served_cnt != 1) begin n_err++; $display("FAIL served_pulse got=%0d want=1", served_cnt); end
    n_chk++; if (cool_cnt != COOL) begin n_err++; $display("FAIL cooldown_len got=%0d want=%0d", cool_cnt, COOL); end
  endtask

  task automatic test_latency();
    int edges;
    rst_n = 1'b0; buton_raw = 1'b0; pietoni_verde = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    buton_raw = 1'b1;
    edges = 0;
    while (buton_pietoni !== 1'b1 && edges < 40) begin
      tick(); edges++;
      n_chk++; if (dut_vec !== exp_vec) begin n_err++; $display("FAIL latency_model cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
    end
    n_chk++; if (edges != LAT) begin n_err++; $display("FAIL latency got=%0d edges want=%0d", edges, LAT); end
    n_chk++; if (press_cnt !== 8'd1) begin n_err++; $display("FAIL latency_cnt got=%0d want=1", press_cnt); end
    repeat (20 - edges) tick();
    buton_raw = 1'b0;
  endtask

  task automatic test_glitch();
    rst_n = 1'b0; buton_raw = 1'b0; pietoni_verde = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int w = 1; w <= DEB; w++) begin
      buton_raw = 1'b1;
      repeat (w) tick();
      buton_raw = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick();
        n_chk++; if (dut_vec !== exp_vec) begin n_err++; $display("FAIL glitch_model w=%0d cyc=%0d got=%h want=%h", w, cyc, dut_vec, exp_vec); end
      end
      if (w == DEB - 1) begin
        n_chk++; if (press_cnt !== 8'd0 || buton_pietoni !== 1'b0) begin n_err++; $display("FAIL glitch_short got cnt=%0d req=%b want cnt=0 req=0", press_cnt, buton_pietoni); end
      end
    end
    n_chk++; if (press_cnt !== 8'd1) begin n_err++; $display("FAIL glitch_full_width got=%0d want=1", press_cnt); end
  endtask

  task automatic test_ignore();
    int sr[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int sv[8] = '{0, 1, 1, 1, 0, 0, 0, 0};
    int sn[8] = '{12, 2, 14, 12, 1, 14, 12, 12};
    rst_n = 1'b0; buton_raw = 1'b0; pietoni_verde = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      buton_raw = (sr[s] != 0); pietoni_verde = (sv[s] != 0);
      for (int c = 0; c < sn[s]; c++) begin
        tick();
        n_chk++; if (dut_vec !== exp_vec) begin n_err++; $display("FAIL ignore_model seg=%0d cyc=%0d got=%h want=%h", s, cyc, dut_vec, exp_vec); end
      end
      if (s == 3) begin
        n_chk++; if (press_cnt !== 8'd1 || buton_pietoni !== 1'b0) begin n_err++; $display("FAIL ignore_serving got cnt=%0d req=%b want cnt=1 req=0", press_cnt, buton_pietoni); end
      end
      if (s == 6) begin
        n_chk++; if (press_cnt !== 8'd1 || req_pending !== 1'b0 || cooldown !== 1'b0) begin n_err++; $display("FAIL ignore_cooldown got cnt=%0d pend=%b cool=%b want 1 0 0", press_cnt, req_pending, cooldown); end
      end
    end
    n_chk++; if (press_cnt !== 8'd2 || buton_pietoni !== 1'b1) begin n_err++; $display("FAIL accept_after_cool got cnt=%0d req=%b want cnt=2 req=1", press_cnt, buton_pietoni); end
  endtask

  task automatic test_reset_pending();
    buton_raw = 1'b0; rst_n = 1'b0;
    tick();
    n_chk++; if (dut_vec !== 12'h000) begin n_err++; $display("FAIL reset_pending got=%h want=000", dut_vec); end
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      n_chk++; if (dut_vec !== exp_vec) begin n_err++; $display("FAIL reset_pending_model cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
    end
    n_chk++; if (buton_pietoni !== 1'b0) begin n_err++; $display("FAIL reset_forgets got=%b want=0", buton_pietoni); end
  endtask

  task automatic test_saturation();
    int sr[3] = '{1, 0, 0};
    int sv[3] = '{0, 1, 0};
    int sn[3] = '{12, 11, 18};
    for (int p = 0; p < 300; p++) begin
      for (int s = 0; s < 3; s++) begin
        buton_raw = (sr[s] != 0); pietoni_verde = (sv[s] != 0);
        for (int c = 0; c < sn[s]; c++) begin
          tick();
          n_chk++; if (dut_vec !== exp_vec) begin n_err++; $display("FAIL sat_model p=%0d cyc=%0d got=%h want=%h", p, cyc, dut_vec, exp_vec); end
        end
      end
    end
    n_chk++; if (press_cnt !== 8'd255) begin n_err++; $display("FAIL saturation got=%0d want=255", press_cnt); end
  endtask

  task automatic test_random();
    int rl = 0, vl = 0;
    for (int c = 0; c < 4000; c++) begin
      if (rl == 0) begin buton_raw = ($urandom_range(0, 1) == 1); rl = $urandom_range(1, 24); end
      if (vl == 0) begin pietoni_verde = ($urandom_range(0, 3) == 0); vl = $urandom_range(1, 40); end
      rst_n = ($urandom_range(0, 599) != 0);
      rl--; vl--;
      tick();
      n_chk++; if (dut_vec !== exp_vec) begin n_err++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; buton_raw = 1'b0; pietoni_verde = 1'b0;
    test_reset();
    test_serve();
    test_latency();
    test_glitch();
    test_ignore();
    test_reset_pending();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
